// File: rtl/sr_bist_pkg.sv
// Shared definitions for the SR flip-flop BIST engine: FSM state encoding,
// directed vector set, LFSR constants and the LFSR step function.
package sr_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DUT_RST,
    ST_DIRECTED,
    ST_RANDOM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [15:0] LFSR_MASK    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam int unsigned NUM_DIRECTED = 5;

  // {s, r} encodings
  localparam logic [1:0] VEC_SET   = 2'b10;
  localparam logic [1:0] VEC_HOLD  = 2'b00;
  localparam logic [1:0] VEC_RESET = 2'b01;
  localparam logic [1:0] VEC_BOTH  = 2'b11;

  // Directed sequence: set, hold, reset, hold, both-asserted.
  function automatic logic [1:0] directed_vec(input logic [2:0] i);
    case (i)
      3'd0:    return VEC_SET;
      3'd1:    return VEC_HOLD;
      3'd2:    return VEC_RESET;
      3'd3:    return VEC_HOLD;
      default: return VEC_BOTH;
    endcase
  endfunction

  // 16-bit Galois LFSR, right shift.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/sr_ff_bist_if.sv
// Control/status handshake between a run requester (master) and the BIST
// engine (slave).
//   start      : one-cycle run request
//   seed       : LFSR seed, sampled with an accepted start
//   busy/done  : run in progress / one-cycle end-of-run pulse
//   pass       : run had no mismatches (held until next accepted start)
//   err_count  : saturating mismatch count
//   first_fail : index of first mismatching vector, all-ones if none
interface sr_ff_bist_if #(
  parameter int unsigned ERR_W = 8,
  parameter int unsigned IDX_W = 16
) ();
  logic             start;
  logic [15:0]      seed;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [IDX_W-1:0] first_fail;

  modport master (
    output start, seed,
    input  busy, done, pass, err_count, first_fail
  );

  modport slave (
    input  start, seed,
    output busy, done, pass, err_count, first_fail
  );
endinterface

// File: rtl/sr_bist_lfsr.sv
// 16-bit Galois LFSR with synchronous load and advance enable.
//   clk, rst_n : clock, async active-low reset (state -> DEFAULT_SEED)
//   i_load     : load i_seed (zero seed replaced by DEFAULT_SEED)
//   i_en       : advance one step
//   o_vec      : low two state bits, used as the {s, r} vector
module sr_bist_lfsr
  import sr_bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [15:0] i_seed,
  input  logic        i_en,
  output logic [1:0]  o_vec
);

  logic [15:0] r_lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= DEFAULT_SEED;
    end else if (i_load) begin
      r_lfsr <= (i_seed == '0) ? DEFAULT_SEED : i_seed;
    end else if (i_en) begin
      r_lfsr <= lfsr_step(r_lfsr);
    end
  end

  assign o_vec = r_lfsr[1:0];

endmodule

// File: rtl/sr_ff_bist.sv
// BIST engine for the SR flip-flop cell: resets the cell, drives a directed
// then pseudo-random {s, r} sequence, and compares q/q_bar against a golden
// model through a CHECK_LAT-deep check pipeline.
//   clk, rst_n          : clock shared with the cell, async active-low reset
//   ctl                 : start/seed request and busy/done/pass/err/first_fail
//   dut_rst_n           : reset to the cell, active-low
//   s_out, r_out        : set/reset drive to the cell
//   q_in, q_bar_in      : cell outputs under test
module sr_ff_bist
  import sr_bist_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 32,
  parameter int unsigned CHECK_LAT   = 1,
  parameter int unsigned ERR_W       = 8,
  parameter int unsigned IDX_W       = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  sr_ff_bist_if.slave  ctl,
  output logic         dut_rst_n,
  output logic         s_out,
  output logic         r_out,
  input  logic         q_in,
  input  logic         q_bar_in
);

  state_t           r_state;
  logic [15:0]      r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             r_dut_rst_n, r_s, r_r;
  logic             r_busy, r_done, r_pass;
  logic [ERR_W-1:0] r_err;
  logic [IDX_W-1:0] r_first_fail;
  logic             r_mq, r_mknown;
  logic             r_pv [CHECK_LAT];
  logic             r_pe [CHECK_LAT];
  logic [IDX_W-1:0] r_pi [CHECK_LAT];

  logic             w_start_acc;
  logic [1:0]       w_lfsr_vec;
  logic             w_lfsr_en;
  logic [1:0]       w_vec;
  logic             w_vec_active;
  logic             w_push_v, w_push_e;
  logic             w_rst_chk;
  logic             w_chk_v, w_chk_e;
  logic [IDX_W-1:0] w_chk_idx;
  logic             w_mismatch;
  logic [ERR_W-1:0] w_err_next;

  assign w_start_acc  = (r_state == ST_IDLE) && ctl.start;
  assign w_vec        = {r_s, r_r};
  assign w_vec_active = (r_state == ST_DIRECTED) || (r_state == ST_RANDOM);

  // The LFSR runs one step ahead of s_out/r_out: it advances on the edge that
  // copies its low bits into the registered outputs, so each random vector is
  // the LFSR value of its own cycle.
  assign w_lfsr_en = ((r_state == ST_DIRECTED) && (r_cnt == 16'(NUM_DIRECTED - 1)))
                   || (r_state == ST_RANDOM);

  sr_bist_lfsr u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_start_acc),
    .i_seed (ctl.seed),
    .i_en   (w_lfsr_en),
    .o_vec  (w_lfsr_vec)
  );

  // Expected response of the vector currently on s_out/r_out; 11 and
  // hold-while-unknown are masked.
  always_comb begin
    w_push_v = 1'b0;
    w_push_e = 1'b0;
    if (w_vec_active) begin
      unique case (w_vec)
        VEC_SET:   begin w_push_v = 1'b1;     w_push_e = 1'b1; end
        VEC_RESET: begin w_push_v = 1'b1;     w_push_e = 1'b0; end
        VEC_HOLD:  begin w_push_v = r_mknown; w_push_e = r_mq; end
        default:   ;
      endcase
    end
  end

  // Reset check is taken directly in the second DUT_RST cycle as index 0;
  // the pipeline is empty then, so the two sources never collide.
  assign w_rst_chk  = (r_state == ST_DUT_RST) && (r_cnt != '0);
  assign w_chk_v    = w_rst_chk || r_pv[CHECK_LAT-1];
  assign w_chk_e    = w_rst_chk ? 1'b0 : r_pe[CHECK_LAT-1];
  assign w_chk_idx  = w_rst_chk ? '0 : r_pi[CHECK_LAT-1];
  assign w_mismatch = w_chk_v && ((q_in != w_chk_e) || (q_bar_in != ~q_in));
  assign w_err_next = (w_mismatch && (r_err != '1)) ? r_err + ERR_W'(1) : r_err;

  // Golden model and check pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mq     <= 1'b0;
      r_mknown <= 1'b1;
      for (int unsigned i = 0; i < CHECK_LAT; i++) begin
        r_pv[i] <= 1'b0;
        r_pe[i] <= 1'b0;
        r_pi[i] <= '0;
      end
    end else begin
      r_pv[0] <= w_push_v;
      r_pe[0] <= w_push_e;
      r_pi[0] <= r_idx;
      for (int unsigned i = 1; i < CHECK_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pe[i] <= r_pe[i-1];
        r_pi[i] <= r_pi[i-1];
      end
      if (w_start_acc) begin
        r_mq     <= 1'b0;
        r_mknown <= 1'b1;
      end else if (w_vec_active) begin
        unique case (w_vec)
          VEC_SET:   begin r_mq <= 1'b1; r_mknown <= 1'b1; end
          VEC_RESET: begin r_mq <= 1'b0; r_mknown <= 1'b1; end
          VEC_BOTH:  r_mknown <= 1'b0;
          default:   ;
        endcase
      end
    end
  end

  // Error accounting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err        <= '0;
      r_first_fail <= '1;
    end else if (w_start_acc) begin
      r_err        <= '0;
      r_first_fail <= '1;
    end else if (w_mismatch) begin
      r_err <= w_err_next;
      if (r_first_fail == '1) r_first_fail <= w_chk_idx;
    end
  end

  // Sequencing FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_dut_rst_n <= 1'b0;
      r_s         <= 1'b0;
      r_r         <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_dut_rst_n <= 1'b1;
          r_s         <= 1'b0;
          r_r         <= 1'b0;
          if (ctl.start) begin
            r_pass      <= 1'b0;
            r_busy      <= 1'b1;
            r_dut_rst_n <= 1'b0;
            r_cnt       <= '0;
            r_state     <= ST_DUT_RST;
          end
        end
        ST_DUT_RST: begin
          if (r_cnt == '0) begin
            r_cnt <= 16'd1;
          end else begin
            r_dut_rst_n <= 1'b1;
            {r_s, r_r}  <= directed_vec(3'd0);
            r_idx       <= IDX_W'(1);
            r_cnt       <= '0;
            r_state     <= ST_DIRECTED;
          end
        end
        ST_DIRECTED: begin
          r_idx <= r_idx + IDX_W'(1);
          if (r_cnt == 16'(NUM_DIRECTED - 1)) begin
            {r_s, r_r} <= w_lfsr_vec;
            r_cnt      <= '0;
            r_state    <= ST_RANDOM;
          end else begin
            {r_s, r_r} <= directed_vec(r_cnt[2:0] + 3'd1);
            r_cnt      <= r_cnt + 16'd1;
          end
        end
        ST_RANDOM: begin
          r_idx <= r_idx + IDX_W'(1);
          if (r_cnt == 16'(NUM_VECTORS - 1)) begin
            r_s     <= 1'b0;
            r_r     <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_DRAIN;
          end else begin
            {r_s, r_r} <= w_lfsr_vec;
            r_cnt      <= r_cnt + 16'd1;
          end
        end
        ST_DRAIN: begin
          if (r_cnt == 16'(CHECK_LAT - 1)) begin
            // last in-flight compare lands on this edge, so use the updated count
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0);
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dut_rst_n      = r_dut_rst_n;
  assign s_out          = r_s;
  assign r_out          = r_r;
  assign ctl.busy       = r_busy;
  assign ctl.done       = r_done;
  assign ctl.pass       = r_pass;
  assign ctl.err_count  = r_err;
  assign ctl.first_fail = r_first_fail;

endmodule

// File: tb/tb_sr_ff_bist.sv
module tb_sr_ff_bist;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sr_ff_bist_if #(.ERR_W(8), .IDX_W(16)) bif ();
  sr_ff_bist_if #(.ERR_W(8), .IDX_W(16)) bbig ();

  logic d0_rst_n, d0_s, d0_r, d0_q, d0_qb;
  logic d1_rst_n, d1_s, d1_r, d1_q, d1_qb;

  sr_ff_bist #(.NUM_VECTORS(32), .CHECK_LAT(1), .ERR_W(8), .IDX_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .ctl(bif.slave), .dut_rst_n(d0_rst_n),
    .s_out(d0_s), .r_out(d0_r), .q_in(d0_q), .q_bar_in(d0_qb));

  sr_ff_bist #(.NUM_VECTORS(1000), .CHECK_LAT(1), .ERR_W(8), .IDX_W(16)) u_big (
    .clk(clk), .rst_n(rst_n), .ctl(bbig.slave), .dut_rst_n(d1_rst_n),
    .s_out(d1_s), .r_out(d1_r), .q_in(d1_q), .q_bar_in(d1_qb));

  // SR cells under test: 11 behaves as reset-dominant (masked by the BIST anyway)
  logic c0_q, c1_q;
  int   fault = 0;   // 0 good, 1 q stuck at 0, 2 q_bar equals q

  always @(posedge clk or negedge d0_rst_n)
    if (!d0_rst_n) c0_q <= 1'b0;
    else if ({d0_s, d0_r} == 2'b10) c0_q <= 1'b1;
    else if (d0_r) c0_q <= 1'b0;

  always @(posedge clk or negedge d1_rst_n)
    if (!d1_rst_n) c1_q <= 1'b0;
    else if ({d1_s, d1_r} == 2'b10) c1_q <= 1'b1;
    else if (d1_r) c1_q <= 1'b0;

  always_comb begin
    d0_q  = c0_q;
    d0_qb = ~c0_q;
    if (fault == 1) d0_q = 1'b0;
    else if (fault == 2) d0_qb = c0_q;
  end
  assign d1_q  = ~c1_q;   // inverted q
  assign d1_qb = c1_q;

  typedef struct packed {
    logic        pass;
    logic [7:0]  err;
    logic [15:0] ff;
    logic [15:0] busy;
  } exp_t;

  exp_t       sb0[$];
  exp_t       sb1[$];
  logic [1:0] exp_log[$];
  logic [1:0] act_log[$];
  int         checks = 0;
  int         errors = 0;
  int         n_done0 = 0;
  int         busy0 = 0;
  int         busy1 = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: vector stream, count of checked vectors and of checked
  // vectors expecting q=1; also fills exp_log (directed + random + drain).
  task automatic model_run(input logic [15:0] seed, input int unsigned n,
                           output int unsigned n_chk, output int unsigned n_one);
    logic [15:0] l;
    logic [1:0]  v;
    logic        mq, mk;
    logic [1:0]  dir [5];
    dir = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b11};
    l = (seed == 16'h0000) ? 16'hACE1 : seed;
    mq = 1'b0; mk = 1'b1; n_chk = 0; n_one = 0;
    exp_log.delete();
    for (int unsigned i = 0; i < 5 + n; i++) begin
      if (i < 5) v = dir[i];
      else begin
        v = l[1:0];
        l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
      end
      exp_log.push_back(v);
      case (v)
        2'b10: begin n_chk++; n_one++; mq = 1'b1; mk = 1'b1; end
        2'b01: begin n_chk++; mq = 1'b0; mk = 1'b1; end
        2'b00: if (mk) begin n_chk++; if (mq) n_one++; end
        default: mk = 1'b0;
      endcase
    end
    exp_log.push_back(2'b00);
  endtask

  task automatic start0(input logic [15:0] sd);
    @(posedge clk); #1;
    bif.start = 1'b1; bif.seed = sd;
    @(posedge clk); #1;
    bif.start = 1'b0;
  endtask

  task automatic wait_done(input bit big, input int unsigned budget, input string name);
    bit seen = 1'b0;
    for (int unsigned i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (big ? bbig.done : bif.done) seen = 1'b1;
    end
    chk(name, longint'(seen), 1);
  endtask

  task automatic chk_log(input string name);
    int bad = 0;
    if (act_log.size() != exp_log.size()) bad = 1000;
    else for (int i = 0; i < exp_log.size(); i++) if (act_log[i] != exp_log[i]) bad++;
    chk(name, bad, 0);
  endtask

  int unsigned nc, n1;
  exp_t        e;
  exp_t        m;

  initial begin
    bif.start = 1'b0; bif.seed = '0;
    bbig.start = 1'b0; bbig.seed = '0;

    fork
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          busy0 = 0; busy1 = 0;
        end else begin
          if (bif.busy) busy0++;
          if (bbig.busy) busy1++;
          if (bif.busy && d0_rst_n && !bif.done) act_log.push_back({d0_s, d0_r});
          if (bif.done) begin
            n_done0++;
            if (sb0.size() == 0) chk("unexpected_done0", 1, 0);
            else begin
              m = sb0.pop_front();
              chk("pass0", bif.pass, m.pass);
              chk("err_count0", bif.err_count, m.err);
              chk("first_fail0", bif.first_fail, m.ff);
              chk("busy_cycles0", busy0, m.busy);
            end
            busy0 = 0;
          end
          if (bbig.done) begin
            if (sb1.size() == 0) chk("unexpected_done1", 1, 0);
            else begin
              m = sb1.pop_front();
              chk("pass1", bbig.pass, m.pass);
              chk("err_count1", bbig.err_count, m.err);
              chk("first_fail1", bbig.first_fail, m.ff);
              chk("busy_cycles1", busy1, m.busy);
            end
            busy1 = 0;
          end
        end
      end
    join_none

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dut_rst_n", d0_rst_n, 0);
    chk("rst_sr", {d0_s, d0_r}, 0);
    chk("rst_busy_done_pass", {bif.busy, bif.done, bif.pass}, 0);
    chk("rst_err_count", bif.err_count, 0);
    chk("rst_first_fail", bif.first_fail, 16'hFFFF);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("dut_rst_n_before_clk", d0_rst_n, 0);
    @(posedge clk); #1;
    chk("dut_rst_n_after_clk", d0_rst_n, 1);

    // good cell, seed 1234
    fault = 0;
    model_run(16'h1234, 32, nc, n1);
    e = '{pass: 1'b1, err: 8'h00, ff: 16'hFFFF, busy: 16'd41};
    sb0.push_back(e);
    act_log.delete();
    start0(16'h1234);
    wait_done(1'b0, 60, "done_good");
    chk_log("vec_log_1234");
    repeat (3) @(posedge clk); #1;
    chk("pass_held", bif.pass, 1);

    // q stuck at 0: errors exactly on checked vectors expecting 1
    fault = 1;
    model_run(16'h1234, 32, nc, n1);
    e = '{pass: 1'b0, err: 8'(n1), ff: 16'd1, busy: 16'd41};
    sb0.push_back(e);
    start0(16'h1234);
    chk("pass_cleared_on_start", bif.pass, 0);
    wait_done(1'b0, 60, "done_stuck0");
    repeat (2) @(posedge clk);

    // q_bar equals q: reset check plus every checked vector fails
    fault = 2;
    model_run(16'h1234, 32, nc, n1);
    e = '{pass: 1'b0, err: 8'(nc + 1), ff: 16'd0, busy: 16'd41};
    sb0.push_back(e);
    start0(16'h1234);
    wait_done(1'b0, 60, "done_qbar");
    repeat (2) @(posedge clk);

    // abort in RANDOM (no scoreboard entry: a done pulse would be flagged)
    fault = 1;
    start0(16'h1234);
    repeat (12) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_dut_rst_n", d0_rst_n, 0);
    chk("abort_sr", {d0_s, d0_r}, 0);
    chk("abort_busy_done_pass", {bif.busy, bif.done, bif.pass}, 0);
    chk("abort_err_count", bif.err_count, 0);
    chk("abort_first_fail", bif.first_fail, 16'hFFFF);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_dut_rst_n_held", d0_rst_n, 0);
    @(posedge clk); #1;
    chk("abort_dut_rst_n_rise", d0_rst_n, 1);
    repeat (50) @(posedge clk); #1;
    chk("abort_idle_busy", bif.busy, 0);

    fault = 0;
    e = '{pass: 1'b1, err: 8'h00, ff: 16'hFFFF, busy: 16'd41};
    sb0.push_back(e);
    start0(16'h0BAD);
    wait_done(1'b0, 60, "done_after_abort");
    repeat (2) @(posedge clk);

    // seed 0 behaves as ACE1; starts while busy and during done are ignored
    fault = 1;
    model_run(16'hACE1, 32, nc, n1);
    e = '{pass: 1'b0, err: 8'(n1), ff: 16'd1, busy: 16'd41};
    sb0.push_back(e);
    act_log.delete();
    start0(16'h0000);
    repeat (8) @(posedge clk);
    start0(16'h1234);
    wait_done(1'b0, 60, "done_seed0");
    bif.start = 1'b1; bif.seed = 16'h1234;
    @(posedge clk); #1;
    bif.start = 1'b0;
    chk_log("vec_log_seed0");
    repeat (3) @(posedge clk); #1;
    chk("start_at_done_ignored", bif.busy, 0);
    repeat (50) @(posedge clk);

    // saturation: inverted q over 1000 random vectors
    model_run(16'h1234, 1000, nc, n1);
    e = '{pass: 1'b0, err: (nc + 1 > 255) ? 8'hFF : 8'(nc + 1), ff: 16'd0, busy: 16'd1009};
    sb1.push_back(e);
    @(posedge clk); #1;
    bbig.start = 1'b1; bbig.seed = 16'h1234;
    @(posedge clk); #1;
    bbig.start = 1'b0;
    wait_done(1'b1, 1200, "done_big");
    repeat (5) @(posedge clk);

    chk("sb0_drained", sb0.size(), 0);
    chk("sb1_drained", sb1.size(), 0);
    chk("done_count0", n_done0, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_ff_bist.md
Name: sr_ff_bist

Overview:
Synthesizable built-in self-test engine for the team's SR flip-flop cell (clk, rst_n, s, r, q, q_bar). It sits on the driving side of the cell. It:
- resets the cell,
- applies a directed vector set followed by LFSR pseudo-random s/r vectors,
- samples q/q_bar,
- compares them against an internal golden model.

It reports pass/fail, an error count and the index of the first failing vector through a start/busy/done handshake.

Parameters:
NUM_VECTORS, 32, number of pseudo-random vectors after the directed set (1..65535)
CHECK_LAT, 1, clocks from the edge that launches s_out/r_out to the edge where the resulting q_in is compared (1..4)
ERR_W, 8, width of err_count (saturating)
IDX_W, 16, width of first_fail

Ports:
clk  in  1  clock, shared with the DUT
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a run; accepted only in IDLE
seed  in  16  LFSR seed, latched on accepted start; 0 is replaced by 16'hACE1
dut_rst_n  out  1  reset to the DUT, active-low
s_out  out  1  set input to the DUT
r_out  out  1  reset input to the DUT
q_in  in  1  DUT q
q_bar_in  in  1  DUT q_bar
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse at end of run
pass  out  1  1 when err_count==0 at done; held until next accepted start
err_count  out  ERR_W  mismatches in current/last run, saturates at all-ones
first_fail  out  IDX_W  index of first mismatching vector; all-ones if none

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low on rst_n. The DUT is clocked on the same clk.
- Reset values:
  - dut_rst_n=0, s_out=0, r_out=0, busy=0, done=0, pass=0, err_count=0, first_fail=all-ones.
  - FSM in IDLE; LFSR=16'hACE1; model q=0, known.
  - dut_rst_n rises on the first clk after rst_n deasserts.
- Reset mid-run: the run is aborted with all outputs at reset values. No done pulse is issued for the aborted run.
- FSM states:
  - IDLE: s_out=r_out=0, dut_rst_n=1. On start: latch seed, clear err_count, set first_fail to all-ones, clear pass, go to DUT_RST. Start in any other state is ignored.
  - DUT_RST (2 cycles): dut_rst_n=0, s/r=0. In the 2nd cycle check q_in==0 && q_bar_in==1 as vector index 0. Then dut_rst_n=1 and go to DIRECTED. Model q=0, known.
  - DIRECTED (5 cycles): one vector per cycle, in order {s,r} = 10, 00, 01, 00, 11, indices 1..5. Then go to RANDOM.
  - RANDOM (NUM_VECTORS cycles): the vector is lfsr[1:0]; the LFSR advances every cycle. Indices are 6..5+NUM_VECTORS. Then go to DRAIN.
  - DRAIN (CHECK_LAT cycles): s/r=0, checks still in flight complete, then go to DONE.
  - DONE (1 cycle): done=1, pass=(err_count==0). Then go to IDLE.
- LFSR: 16-bit Galois, right-shift, mask 16'hB400.
- Golden model, updated per vector:
  - 10 gives q=1, known.
  - 01 gives q=0, known.
  - 00 holds the current value and known flag.
  - 11 marks the model unknown.
- Check masking: a vector is masked if it is 11, or if it is 00 while the model is unknown. Masked vectors are not checked.
- Check pipeline: the expected q, a valid flag and the index are delayed CHECK_LAT stages. At each compare edge, with valid=1, a mismatch is (q_in != expected) OR (q_bar_in != ~q_in).
- On mismatch:
  - err_count increments, saturating.
  - first_fail is written only while it is still all-ones.
- busy=1 in DUT_RST, DIRECTED, RANDOM, DRAIN and DONE.
- Simultaneous start and done: start is ignored, because the FSM is in DONE, not IDLE.

Decomposition:
- Package sr_bist_pkg: FSM state enum, directed vector constants, LFSR mask 16'hB400, default seed 16'hACE1.
- Sub-module sr_bist_lfsr (16-bit Galois LFSR with load/enable). The rest, including the FSM, golden model and check pipeline, lives in the top.

Test Plan:
- Good SR FF DUT, seed=16'h1234, NUM_VECTORS=32: start pulse leads to busy for 2+5+32+1+1 = 41 cycles, then done pulse, pass=1, err_count=0, first_fail=16'hFFFF.
- DUT with q stuck at 0: fail at index 1 (set), so first_fail=1, pass=0, err_count>=1 and equal to the count of unmasked vectors expecting q=1.
- DUT whose q_bar equals q: reset check fails, so first_fail=0, pass=0.
- Assert rst_n=0 in the middle of RANDOM, then release: all outputs at reset values, no done pulse. dut_rst_n returns to 1 one clk after release. A new start then runs cleanly to pass=1.
- Start while busy, and seed=0: the extra start is ignored (exactly one done pulse). With seed=0, the random vector sequence is identical to a run with seed=16'hACE1.
- Faulty DUT with >255 mismatches (NUM_VECTORS=1000, q inverted): err_count saturates at 8'hFF.
